// File: rtl/io_port_buffer_if.sv
// Bus bundle for io_port_buffer: device input stream, CPU pop/write side, output handshake, sticky status.
// Adds a loopback control when IO_LOOPBACK_EN is defined.
interface io_port_buffer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 3
);
`ifdef IO_LOOPBACK_EN
  logic                  loopback;
`endif
  logic [DATA_WIDTH-1:0] dev_in_data;
  logic                  dev_in_valid;
  logic                  dev_in_ready;
  logic                  in_read;
  logic [DATA_WIDTH-1:0] in_data_out;
  logic                  in_empty;
  logic                  in_full;
  logic [CNT_WIDTH-1:0]  in_count;
  logic                  out_write;
  logic [DATA_WIDTH-1:0] out_data_in;
  logic [DATA_WIDTH-1:0] OutPort_data_out;
  logic                  out_valid;
  logic                  dev_out_ack;
  logic                  clear_flags;
  logic                  overrun;
  logic                  underflow;

  // Buffer side
  modport slave (
`ifdef IO_LOOPBACK_EN
    input  loopback,
`endif
    input  dev_in_data, dev_in_valid, in_read, out_write, out_data_in,
           dev_out_ack, clear_flags,
    output dev_in_ready, in_data_out, in_empty, in_full, in_count,
           OutPort_data_out, out_valid, overrun, underflow
  );

  // Device/CPU side
  modport master (
`ifdef IO_LOOPBACK_EN
    output loopback,
`endif
    output dev_in_data, dev_in_valid, in_read, out_write, out_data_in,
           dev_out_ack, clear_flags,
    input  dev_in_ready, in_data_out, in_empty, in_full, in_count,
           OutPort_data_out, out_valid, overrun, underflow
  );
endinterface

// File: rtl/io_port_buffer.sv
// Input FIFO plus held output word with valid/ack handshake and sticky overrun/underflow status.
// Optional IO_LOOPBACK_EN routes CPU output writes into the input FIFO while loopback=1.
module io_port_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IN_DEPTH   = 4,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input logic             clock,
  input logic             reset,
  io_port_buffer_if.slave bus
);

  localparam int unsigned PTR_WIDTH = CNT_WIDTH - 1;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } out_state_t;

  logic [DATA_WIDTH-1:0] mem [IN_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q;
  logic [PTR_WIDTH-1:0]  rd_ptr_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [DATA_WIDTH-1:0] in_data_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  out_state_t            state_q;
  out_state_t            state_d;
  logic                  overrun_q;
  logic                  underflow_q;

  logic                  full_c;
  logic                  empty_c;
  logic                  dev_ready_c;
  logic                  push_c;
  logic                  pop_c;
  logic [DATA_WIDTH-1:0] push_data_c;
  logic                  load_out_c;
  logic                  overrun_set_c;
  logic                  underflow_set_c;

  // FIFO control, output-port next state and flag set events
  always_comb begin
    full_c          = (count_q == CNT_WIDTH'(IN_DEPTH));
    empty_c         = (count_q == '0);
    dev_ready_c     = !full_c;
    push_c          = bus.dev_in_valid && !full_c;
    push_data_c     = bus.dev_in_data;
    pop_c           = bus.in_read && !empty_c;
    underflow_set_c = bus.in_read && empty_c;
    state_d         = state_q;
    load_out_c      = 1'b0;
    overrun_set_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.out_write) begin
          load_out_c = 1'b1;
          state_d    = HELD;
        end
      end
      HELD: begin
        if (bus.out_write) begin
          load_out_c    = 1'b1;
          overrun_set_c = !bus.dev_out_ack;
        end else if (bus.dev_out_ack) begin
          state_d = IDLE;
        end
      end
    endcase

`ifdef IO_LOOPBACK_EN
    // Loopback: CPU writes feed the FIFO, device input blocked, output port frozen
    if (bus.loopback) begin
      dev_ready_c   = 1'b0;
      push_c        = bus.out_write && !full_c;
      push_data_c   = bus.out_data_in;
      state_d       = state_q;
      load_out_c    = 1'b0;
      overrun_set_c = bus.out_write && full_c;
    end
`endif
  end

  // FIFO storage carries no reset; contents behind the pointers are don't-care
  always_ff @(posedge clock) begin
    if (push_c) begin
      mem[wr_ptr_q] <= push_data_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      in_data_q <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
      end
      if (pop_c) begin
        rd_ptr_q  <= rd_ptr_q + PTR_WIDTH'(1);
        in_data_q <= mem[rd_ptr_q];
      end
      count_q <= count_q + CNT_WIDTH'(push_c) - CNT_WIDTH'(pop_c);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_data_q <= '0;
    end else if (load_out_c) begin
      out_data_q <= bus.out_data_in;
    end
  end

  // Set events take priority over a coincident clear
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overrun_q   <= overrun_set_c   || (overrun_q   && !bus.clear_flags);
      underflow_q <= underflow_set_c || (underflow_q && !bus.clear_flags);
    end
  end

  assign bus.dev_in_ready     = dev_ready_c;
  assign bus.in_data_out      = in_data_q;
  assign bus.in_empty         = empty_c;
  assign bus.in_full          = full_c;
  assign bus.in_count         = count_q;
  assign bus.OutPort_data_out = out_data_q;
  assign bus.out_valid        = (state_q == HELD);
  assign bus.overrun          = overrun_q;
  assign bus.underflow        = underflow_q;

endmodule
